// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encoding,
// opcodes, ALU operation codes and datapath mux select values.
// Also used by alu_control for the ALUOP_* codes.
package mips_ctrl_pkg;

  // Encodings 10-15 are never entered in normal operation
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States in which the FSM is waiting on the memory handshake
  function automatic logic is_mem_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// master = control FSM (drives enables/selects), slave = datapath/memory.
// mem_ready is the only handshake; the FSM holds its request until it is seen.
interface multicycle_control_if;
  logic [5:0] instruction_31_26;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal_op;
  logic       mem_timeout;

  modport master (
    input  instruction_31_26, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           alu_op, state, instr_done, illegal_op, mem_timeout
  );

  modport slave (
    output instruction_31_26, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           alu_op, state, instr_done, illegal_op, mem_timeout
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles and flags when a wait has to be abandoned.
// Timeout is combinational in the cycle the count reaches MEM_WAIT_MAX.
// mem_ready always wins over the timeout; MEM_WAIT_MAX=0 never times out.
module mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_i,
  input  logic mem_ready_i,
  input  logic state_chg_i,
  output logic timeout_o
);

  localparam int CW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MEM_WAIT_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout_o = (MEM_WAIT_MAX > 0) && wait_i && !mem_ready_i && (cnt_q == CNT_MAX);

  // Clear on any state change or abandon (FETCH re-entry keeps the same state), else saturating count
  always_comb begin
    cnt_d = cnt_q;
    if (state_chg_i || timeout_o) begin
      cnt_d = '0;
    end else if (wait_i && !mem_ready_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_control.sv
// Main multicycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback.
// Moore outputs on state; FETCH/MEM_READ/MEM_WRITE enables qualified by mem_ready.
// Waits in memory states until mem_ready or until the wait timer abandons the access.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master ctrl
);

  state_t state_q, state_d;
  logic   wait_cycle;
  logic   state_chg;
  logic   timeout;
  logic   legal_op;

  assign wait_cycle = is_mem_wait_state(state_q);
  assign state_chg  = (state_d != state_q);
  assign ctrl.state = state_q;

  mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_wait_timer (
    .clk         (clk),
    .rst         (rst),
    .wait_i      (wait_cycle),
    .mem_ready_i (ctrl.mem_ready),
    .state_chg_i (state_chg),
    .timeout_o   (timeout)
  );

  // Recognised opcodes; anything else is reported and dropped in DECODE
  always_comb begin
    legal_op = 1'b0;
    case (ctrl.instruction_31_26)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: legal_op = 1'b1;
      default:                              legal_op = 1'b0;
    endcase
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (ctrl.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (ctrl.instruction_31_26)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (ctrl.instruction_31_26 == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (ctrl.mem_ready)  state_d = S_MEM_WB;
        else if (timeout)    state_d = S_FETCH;
      end
      S_MEM_WRITE: if (ctrl.mem_ready || timeout) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Datapath controls decoded from state; everything forced low while in reset
  always_comb begin
    ctrl.pc_write      = 1'b0;
    ctrl.pc_write_cond = 1'b0;
    ctrl.pc_source     = PCSRC_ALU;
    ctrl.i_or_d        = 1'b0;
    ctrl.mem_read      = 1'b0;
    ctrl.mem_write     = 1'b0;
    ctrl.ir_write      = 1'b0;
    ctrl.mem_to_reg    = 1'b0;
    ctrl.reg_dst       = 1'b0;
    ctrl.reg_write     = 1'b0;
    ctrl.alu_src_a     = 1'b0;
    ctrl.alu_src_b     = SRCB_REG;
    ctrl.alu_op        = ALUOP_ADD;
    ctrl.instr_done    = 1'b0;
    ctrl.illegal_op    = 1'b0;
    ctrl.mem_timeout   = 1'b0;
    if (!rst) begin
      ctrl.mem_timeout = timeout;
      case (state_q)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.ir_write  = ctrl.mem_ready;
          ctrl.pc_write  = ctrl.mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_b  = SRCB_IMM_SL2;
          ctrl.illegal_op = !legal_op;
        end
        S_MEM_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
        end
        S_MEM_READ: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          ctrl.mem_write  = !timeout;
          ctrl.i_or_d     = 1'b1;
          ctrl.instr_done = ctrl.mem_ready;
        end
        S_R_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        S_R_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_op        = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
          ctrl.instr_done    = 1'b1;
        end
        S_JUMP: begin
          ctrl.pc_write   = 1'b1;
          ctrl.pc_source  = PCSRC_JUMP;
          ctrl.instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: instruction-level reference model builds
// a per-cycle expected trace; driver applies it, monitor compares at negedge.
module tb_multicycle_control;

  localparam int   WAIT_MAX = 4;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct packed {
    logic        r;
    logic        mr;
    logic [5:0]  op;
    logic [3:0]  st;
    logic [18:0] ov;
  } stim_t;

  logic clk;
  logic rst;
  multicycle_control_if bus();

  multicycle_control #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  stim_t stim_q[$];
  stim_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    ncyc  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector, order: pc_write pc_write_cond pc_source i_or_d mem_read
  // mem_write ir_write mem_to_reg reg_dst reg_write alu_src_a alu_src_b alu_op
  // instr_done illegal_op mem_timeout
  function automatic logic [18:0] o(input logic pcw, pcwc, input logic [1:0] pcs,
                                    input logic iord, mrd, mwr, irw, m2r, rdst, rw, asa,
                                    input logic [1:0] asb, aop,
                                    input logic done, ill, tmo);
    return {pcw, pcwc, pcs, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, done, ill, tmo};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
           (op == 6'b000100) || (op == 6'b000010);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic push(input logic r, input logic mr, input logic [5:0] op,
                      input logic [3:0] st, input logic [18:0] ov);
    stim_t s;
    s.r = r; s.mr = mr; s.op = op; s.st = st; s.ov = ov;
    stim_q.push_back(s);
  endtask

  // Instruction fetch: fw cycles without ready (abandoned every WAIT_MAX+1), then a ready cycle
  task automatic gen_fetch(input int fw);
    for (int i = 0; i < fw; i++)
      push(L, L, rop(), 4'd0, o(L,L,2'b00,L,H,L,L,L,L,L,L,2'b01,2'b00,L,L,
                               (i % (WAIT_MAX + 1)) == WAIT_MAX));
    push(L, H, rop(), 4'd0, o(H,L,2'b00,L,H,L,H,L,L,L,L,2'b01,2'b00,L,L,L));
  endtask

  task automatic gen_decode(input logic [5:0] op);
    push(L, rb(), op, 4'd1, o(L,L,2'b00,L,L,L,L,L,L,L,L,2'b11,2'b00,L,!is_legal(op),L));
  endtask

  // One whole instruction: fetch wait fw, memory-phase wait mw
  task automatic gen_instr(input logic [5:0] op, input int fw, input int mw);
    logic t;
    gen_fetch(fw);
    gen_decode(op);
    if (!is_legal(op)) return;
    case (op)
      6'b000000: begin
        push(L, rb(), op, 4'd6, o(L,L,2'b00,L,L,L,L,L,L,L,H,2'b00,2'b10,L,L,L));
        push(L, rb(), op, 4'd7, o(L,L,2'b00,L,L,L,L,L,H,H,L,2'b00,2'b00,H,L,L));
      end
      6'b100011, 6'b101011: begin
        push(L, rb(), op, 4'd2, o(L,L,2'b00,L,L,L,L,L,L,L,H,2'b10,2'b00,L,L,L));
        for (int i = 0; i < mw; i++) begin
          t = (i == WAIT_MAX);
          if (op == 6'b100011)
            push(L, L, op, 4'd3, o(L,L,2'b00,H,H,L,L,L,L,L,L,2'b00,2'b00,L,L,t));
          else
            push(L, L, op, 4'd5, o(L,L,2'b00,H,L,!t,L,L,L,L,L,2'b00,2'b00,L,L,t));
          if (t) return;
        end
        if (op == 6'b100011) begin
          push(L, H, op, 4'd3, o(L,L,2'b00,H,H,L,L,L,L,L,L,2'b00,2'b00,L,L,L));
          push(L, rb(), op, 4'd4, o(L,L,2'b00,L,L,L,L,H,L,H,L,2'b00,2'b00,H,L,L));
        end else begin
          push(L, H, op, 4'd5, o(L,L,2'b00,H,L,H,L,L,L,L,L,2'b00,2'b00,H,L,L));
        end
      end
      6'b000100:
        push(L, rb(), op, 4'd8, o(L,H,2'b01,L,L,L,L,L,L,L,H,2'b00,2'b01,H,L,L));
      default:
        push(L, rb(), op, 4'd9, o(H,L,2'b10,L,L,L,L,L,L,L,L,2'b00,2'b00,H,L,L));
    endcase
  endtask

  // sw cut off by reset arriving just after MEM_WRITE is entered
  task automatic gen_sw_reset(input int ncyc_rst);
    gen_fetch(0);
    gen_decode(6'b101011);
    push(L, rb(), 6'b101011, 4'd2, o(L,L,2'b00,L,L,L,L,L,L,L,H,2'b10,2'b00,L,L,L));
    for (int i = 0; i < ncyc_rst; i++)
      push(H, H, 6'b101011, 4'd0, 19'd0);
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] op;
    case ($urandom_range(0, 9))
      0, 1, 9: op = 6'b000000;
      2, 3:    op = 6'b100011;
      4, 5:    op = 6'b101011;
      6:       op = 6'b000100;
      7:       op = 6'b000010;
      default: begin
        op = rop();
        while (is_legal(op)) op = rop();
      end
    endcase
    return op;
  endfunction

  function automatic int pick_wait();
    if ($urandom_range(0, 6) == 0) return $urandom_range(3, 11);
    return $urandom_range(0, 2);
  endfunction

  // Driver: builds the trace, then applies one cycle per clock just after the edge
  initial begin
    stim_t s;
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    bus.instruction_31_26 = 6'd0;
    #1 rst = 1'b1;

    push(H, H, rop(), 4'd0, 19'd0);
    push(H, L, rop(), 4'd0, 19'd0);
    gen_instr(6'b000000, 0, 0);   // R-type, no waits
    gen_instr(6'b100011, 0, 3);   // lw, 3 wait cycles in MEM_READ
    gen_instr(6'b101011, 0, 0);   // sw
    gen_instr(6'b000100, 0, 0);   // beq
    gen_instr(6'b111111, 0, 0);   // illegal
    gen_instr(6'b000010, 5, 0);   // j after a fetch timeout
    gen_instr(6'b000000, 10, 0);  // two consecutive fetch timeouts
    gen_instr(6'b100011, 0, 5);   // lw abandoned in MEM_READ
    gen_instr(6'b101011, 0, 7);   // sw abandoned in MEM_WRITE
    gen_sw_reset(2);
    gen_instr(6'b101011, 0, 1);
    for (int n = 0; n < 250; n++) begin
      if (n % 60 == 30) gen_sw_reset(1 + (n % 2));
      gen_instr(pick_op(), pick_wait(), pick_wait());
    end

    while (stim_q.size() > 0) begin
      @(posedge clk);
      #1;
      s = stim_q.pop_front();
      rst = s.r;
      bus.mem_ready = s.mr;
      bus.instruction_31_26 = s.op;
      exp_q.push_back(s);
    end
    repeat (3) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Monitor: compares the DUT against the scoreboard once per cycle, mid-cycle
  always @(negedge clk) begin
    stim_t       e;
    logic [18:0] act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      ncyc++;
      act = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d, bus.mem_read,
             bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
             bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.instr_done, bus.illegal_op,
             bus.mem_timeout};
      tests++;
      if (bus.state !== e.st) begin
        fails++;
        $display("FAIL state cyc %0d (rst=%0b op=%b mr=%0b): got %0d required %0d",
                 ncyc, e.r, e.op, e.mr, bus.state, e.st);
      end
      tests++;
      if (act !== e.ov) begin
        fails++;
        $display("FAIL outputs cyc %0d state %0d (rst=%0b op=%b mr=%0b): got %b required %b",
                 ncyc, e.st, e.r, e.op, e.mr, act, e.ov);
      end
    end
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sits directly upstream of alu_control and supplies its alu_op field.
- Sequences each instruction through fetch, decode, execute, memory and writeback using the opcode (instruction bits 31:26) and a memory-ready handshake.
- Drives every datapath enable and mux select.

Parameters:
- MEM_WAIT_MAX, 15: cycles spent waiting for mem_ready before the access is abandoned; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- instruction_31_26  in  6  opcode from the instruction register; stable from DECODE to the end of the instruction
- mem_ready  in  1  memory has completed the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by ALU zero (branch)
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  register write data: 0 ALUOut, 1 MDR
- reg_dst  out  1  destination register: 0 rt, 1 rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A input: 0 PC, 1 register A
- alu_src_b  out  2  ALU B input: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left 2
- alu_op  out  2  to alu_control: 00 add, 01 subtract, 10 decode funct
- state  out  4  current state, for debug and verification
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal_op  out  1  one-cycle pulse on an unknown opcode
- mem_timeout  out  1  one-cycle pulse when a memory wait is abandoned

Behaviour:
- States and encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9.
- Encodings 10-15 are unreachable; if entered, the next state is FETCH and all outputs are 0.
- Reset: state is set to FETCH asynchronously and the wait counter to 0. While rst=1 every output is forced to 0, except state, which reads 0 (FETCH).
- Output type: Moore on state, except that the FETCH/MEM_READ/MEM_WRITE enables are gated by mem_ready as noted below. Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready. Go to DECODE on mem_ready, otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 000000 -> R_EXEC
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - any other opcode -> FETCH, with illegal_op=1 for this cycle
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, i_or_d=1. Go to MEM_WB on mem_ready.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Go to FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1, instr_done=mem_ready. Go to FETCH on mem_ready.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Go to FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Go to FETCH.
- Latency in cycles with zero memory wait: R-type 4, lw 5, sw 4, beq 3, j 3.
- Wait counter:
  - Cleared on every state change.
  - Increments in each FETCH, MEM_READ or MEM_WRITE cycle with mem_ready=0; saturates at MEM_WAIT_MAX.
  - If MEM_WAIT_MAX>0, the counter equals MEM_WAIT_MAX and mem_ready=0: mem_timeout=1 for that cycle, next state is FETCH, and no write or IR/PC enable is asserted.
  - If mem_ready and the timeout condition coincide, mem_ready wins.
  - Counter width is clog2(MEM_WAIT_MAX+1), minimum 1.
- Reset asserted mid-instruction: the FSM aborts immediately; no partial writes follow deassertion; the first cycle after release is FETCH.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the state enum
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J
  - alu_op constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - alu_src_b and pc_source select constants
- alu_control imports ALUOP_* from the same package.
- One sub-module: mem_wait_timer (counter plus timeout compare), parameterised by MEM_WAIT_MAX.

Test Plan:
- R-type, opcode 000000, mem_ready=1 throughout -> states 0,1,6,7. alu_op=10 in R_EXEC. reg_write=1 and reg_dst=1 in R_WB. instr_done pulses once, in cycle 4.
- lw, opcode 100011, mem_ready low for 3 cycles in MEM_READ -> states 0,1,2,3,3,3,3,4. mem_read=1 and i_or_d=1 while waiting. MEM_WB has mem_to_reg=1 and reg_write=1.
- sw, opcode 101011, then beq, opcode 000100 ->
  - sw: mem_write=1 for exactly one ready cycle.
  - beq: BRANCH has alu_op=01, pc_write_cond=1, pc_source=01; back to FETCH after 3 cycles.
- Illegal opcode 111111 -> illegal_op pulses in DECODE; state returns to 0; no reg_write or mem_write is asserted.
- MEM_WAIT_MAX=4, mem_ready held 0 in FETCH -> mem_timeout=1 on the 5th FETCH cycle; ir_write and pc_write never asserted; FETCH re-entered with the counter cleared.
- rst asserted asynchronously in MEM_WRITE -> all outputs 0 immediately and state=0. After release the FSM restarts in FETCH with mem_write=0.
